// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage operand interface between ID and the hazard scoreboard
// master: decode stage driving operand/destination info; slave: the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] Ra_ID;
  logic [REG_AW-1:0] Rb_ID;
  logic              useA_ID;
  logic              useB_ID;
  logic [REG_AW-1:0] Rd_ID;
  logic              RegWrite_ID;
  logic              MemRead_ID;
  logic              flush_ID;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              stall;
  logic              bubble_EX;
  logic              WB_signals;
  logic [REG_AW-1:0] DestinationRegister;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output Ra_ID, Rb_ID, useA_ID, useB_ID, Rd_ID, RegWrite_ID, MemRead_ID, flush_ID,
    input  ForwardA, ForwardB, stall, bubble_EX, WB_signals, DestinationRegister, stall_count
  );

  modport slave (
    input  Ra_ID, Rb_ID, useA_ID, useB_ID, Rd_ID, RegWrite_ID, MemRead_ID, flush_ID,
    output ForwardA, ForwardB, stall, bubble_EX, WB_signals, DestinationRegister, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination-tag scoreboard: forwarding, load-use stall, regfile write
// Optional R0_ZERO_EN: register 0 hardwired to zero (never forwarded, stalled on, or written).
module hazard_scoreboard #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  sb
);

  // The load flag only matters while the producer sits in EX, so MEM/WB tags carry wr/rd only.
  logic              ex_wr, ex_load, mem_wr, wb_wr;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0]  stall_cnt;

  logic ex_wv, mem_wv, wb_wv;
  logic hz;

`ifdef R0_ZERO_EN
  assign ex_wv  = ex_wr  & (ex_rd  != '0);
  assign mem_wv = mem_wr & (mem_rd != '0);
  assign wb_wv  = wb_wr  & (wb_rd  != '0);
`else
  assign ex_wv  = ex_wr;
  assign mem_wv = mem_wr;
  assign wb_wv  = wb_wr;
`endif

  function automatic logic [1:0] fwd_sel(
    input logic              use_r,
    input logic [REG_AW-1:0] r,
    input logic              exv,
    input logic [REG_AW-1:0] exr,
    input logic              memv,
    input logic [REG_AW-1:0] memr,
    input logic              wbv,
    input logic [REG_AW-1:0] wbr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r) begin
      // Youngest producer wins.
      if (exv && exr == r)        sel = 2'b01;
      else if (memv && memr == r) sel = 2'b10;
      else if (wbv && wbr == r)   sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    sb.ForwardA = fwd_sel(sb.useA_ID, sb.Ra_ID, ex_wv, ex_rd, mem_wv, mem_rd, wb_wv, wb_rd);
    sb.ForwardB = fwd_sel(sb.useB_ID, sb.Rb_ID, ex_wv, ex_rd, mem_wv, mem_rd, wb_wv, wb_rd);
  end

  assign hz = ex_load & ex_wv &
              ((sb.useA_ID & (ex_rd == sb.Ra_ID)) | (sb.useB_ID & (ex_rd == sb.Rb_ID)));

  // A flush discards the consumer, so holding the front end would be pointless.
  assign sb.stall               = hz & ~sb.flush_ID;
  assign sb.bubble_EX           = hz | sb.flush_ID;
  assign sb.WB_signals          = wb_wv;
  assign sb.DestinationRegister = wb_rd;
  assign sb.stall_count         = stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= '0;
      wb_wr     <= 1'b0;
      wb_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      wb_wr  <= mem_wr;
      wb_rd  <= mem_rd;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (sb.bubble_EX) begin
        ex_wr   <= 1'b0;
        ex_load <= 1'b0;
        ex_rd   <= '0;
      end else begin
        ex_wr   <= sb.RegWrite_ID;
        ex_load <= sb.MemRead_ID;
        ex_rd   <= sb.Rd_ID;
      end
      if (sb.stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven bench for hazard_scoreboard (4-bit stall counter build)
module tb_hazard_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.REG_AW(3), .CNT_W(4)) bus ();

  hazard_scoreboard #(.REG_AW(3), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ra, rb, rd;
    logic       ua, ub, rw, mr, fl;
    logic [1:0] fa, fb;
    logic       st, bub, wb;
    logic [2:0] dest;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(
    input logic [2:0] ra, input logic [2:0] rb, input logic ua, input logic ub,
    input logic [2:0] rd, input logic rw, input logic mr, input logic fl,
    input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic bub,
    input logic wb, input logic [2:0] dest, input logic [3:0] cnt
  );
    vec_t v;
    v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub; v.rd = rd; v.rw = rw; v.mr = mr; v.fl = fl;
    v.fa = fa; v.fb = fb; v.st = st; v.bub = bub; v.wb = wb; v.dest = dest; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ra, input logic [2:0] rb, input logic ua, input logic ub,
                       input logic [2:0] rd, input logic rw, input logic mr, input logic fl);
    bus.Ra_ID = ra; bus.Rb_ID = rb; bus.useA_ID = ua; bus.useB_ID = ub;
    bus.Rd_ID = rd; bus.RegWrite_ID = rw; bus.MemRead_ID = mr; bus.flush_ID = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_cnt;
  logic [1:0] exp_r0_fa;
  logic       exp_r0_wb;

  initial begin
    checks   = 0;
    failures = 0;

    //          ra rb ua ub rd rw mr fl   fa fb st bub wb dest cnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(3, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(3, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(3, 0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 1, 3, 0);
    vecs[5]  = mk(3, 0, 1, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(5, 5, 1, 1, 5, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[8]  = mk(5, 5, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 5, 0);
    vecs[9]  = mk(5, 5, 1, 1, 0, 0, 0, 0,  2, 2, 0, 0, 1, 5, 0);
    vecs[10] = mk(0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0, 1, 5, 0);
    vecs[11] = mk(0, 2, 0, 1, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0, 0);
    vecs[12] = mk(0, 2, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0, 1, 2, 1);
    vecs[14] = mk(0, 2, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 4, 1, 0, 1,  0, 0, 0, 1, 1, 2, 1);
    vecs[17] = mk(4, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
    end
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].ua, vecs[i].ub,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_ForwardA", i), 32'(bus.ForwardA), 32'(vecs[i].fa));
      chk($sformatf("v%0d_ForwardB", i), 32'(bus.ForwardB), 32'(vecs[i].fb));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].st));
      chk($sformatf("v%0d_bubble_EX", i), 32'(bus.bubble_EX), 32'(vecs[i].bub));
      chk($sformatf("v%0d_WB_signals", i), 32'(bus.WB_signals), 32'(vecs[i].wb));
      chk($sformatf("v%0d_DestReg", i), 32'(bus.DestinationRegister), 32'(vecs[i].dest));
      chk($sformatf("v%0d_stall_count", i), 32'(bus.stall_count), 32'(vecs[i].cnt));
      next_cycle();
    end

    // Repeated load-use pairs drive the 4-bit counter into saturation.
    exp_cnt = 4'd1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 1, 1, 1, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_load_stall", k), 32'(bus.stall), 32'd0);
      next_cycle();
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_use_stall", k), 32'(bus.stall), 32'd1);
      next_cycle();
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      chk($sformatf("sat%0d_stall_count", k), 32'(bus.stall_count), 32'(exp_cnt));
    end

`ifdef R0_ZERO_EN
    exp_r0_fa = 2'b00;
    exp_r0_wb = 1'b0;
`else
    exp_r0_fa = 2'b01;
    exp_r0_wb = 1'b1;
`endif
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_ForwardA", 32'(bus.ForwardA), 32'(exp_r0_fa));
    chk("r0_stall", 32'(bus.stall), 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("r0_WB_signals", 32'(bus.WB_signals), 32'(exp_r0_wb));
    chk("r0_DestReg", 32'(bus.DestinationRegister), 32'd0);
    next_cycle();

    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_stall_count", 32'(bus.stall_count), 32'd0);
    chk("rst2_WB_signals", 32'(bus.WB_signals), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
